mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 0: extra RAM access cycles added beyond the first.
REQ-002 Parameter STARVE_MAX, default 3: number of consecutive lost ties that forces an IF win. A value of 0 means IF wins every tie.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 if_req  in  1  fetch request; held by the requester until if_ack.
REQ-006 if_addr  in  9  fetch byte address.
REQ-007 if_rdata  out  32  registered fetch word.
REQ-008 if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 dm_req  in  1  data request; held by the requester until dm_ack.
REQ-010 dm_rw  in  1  1 = store, 0 = load.
REQ-011 dm_size  in  2  access size, passed through to mem_size.
REQ-012 dm_se  in  1  load sign-extend, passed through to mem_se.
REQ-013 dm_addr  in  9  data byte address.
REQ-014 dm_wdata  in  32  store data.
REQ-015 dm_rdata  out  32  registered load data.
REQ-016 dm_ack  out  1  one-cycle data completion pulse.
REQ-017 mem_a  out  9  shared RAM address.
REQ-018 mem_di  out  32  shared RAM write data.
REQ-019 mem_size  out  2  shared RAM size.
REQ-020 mem_rw  out  1  shared RAM write enable.
REQ-021 mem_e  out  1  shared RAM enable.
REQ-022 mem_se  out  1  shared RAM sign-extend.
REQ-023 mem_do  in  32  shared RAM read data.
REQ-024 gnt_if  out  1  IF owns the RAM (high in ACC only).
REQ-025 gnt_dm  out  1  DM owns the RAM (high in ACC only).

Function
REQ-026 The FSM SHALL have states IDLE, ACC and RESP; the reset state is IDLE.
REQ-027 IDLE SHALL sample requests; if any is pending, the next edge SHALL move to ACC, latch the winner, latch its addr/rw/size/se/wdata, and load wcnt=WAIT_CYCLES.
REQ-028 Fetch grants SHALL latch rw=0, size=2'b10 and se=0.
REQ-029 Arbitration SHALL give DM the grant when only dm_req is high, and IF the grant when only if_req is high.
REQ-030 On a tie, IF SHALL win when starve_cnt>=STARVE_MAX; otherwise DM SHALL win.
REQ-031 starve_cnt SHALL increment, saturating at STARVE_MAX, whenever IF loses a tie, and SHALL clear whenever IF is granted.
REQ-032 In ACC the arbiter SHALL drive mem_e=1 and the mem_a/mem_di/mem_size/mem_rw/mem_se values from the latched fields only; requester input changes during ACC SHALL be ignored.
REQ-033 In ACC, wcnt SHALL decrement each edge while nonzero; the edge at which wcnt==0 SHALL capture mem_do and move to RESP.
REQ-034 On a fetch, the captured mem_do SHALL go to if_rdata.
REQ-035 On a load, the captured mem_do SHALL go to dm_rdata.
REQ-036 On a store, neither rdata register SHALL change.
REQ-037 RESP SHALL assert exactly the winner's ack for one cycle and SHALL return to IDLE on the next edge; no grant SHALL be made in RESP.
REQ-038 Latency: with a request first seen in IDLE at cycle 0, ACC SHALL occupy cycles 1..WAIT_CYCLES+1 and the ack SHALL be high in cycle WAIT_CYCLES+2.
REQ-039 Outside ACC, mem_e, mem_rw, gnt_if and gnt_dm SHALL be 0, and mem_a, mem_di, mem_size and mem_se SHALL be 0.
REQ-040 A request dropped during ACC SHALL still complete, and its ack SHALL still pulse.
REQ-041 A requester still asserting req in IDLE after its ack SHALL be treated as a new request.
REQ-042 if_rdata and dm_rdata SHALL hold their values between completions.

Reset
REQ-043 Asserting reset SHALL immediately force IDLE, clear starve_cnt, wcnt, if_rdata, dm_rdata, if_ack, dm_ack, gnt_* and all mem_* outputs to 0, and hold that state while reset is high.
REQ-044 Reset during ACC SHALL drop mem_e/mem_rw combinationally; no ack SHALL be issued for the aborted access.
REQ-045 The first grant after reset release SHALL occur no earlier than the first rising edge with reset low.

Verification (WAIT_CYCLES=1, STARVE_MAX=2 unless noted)
REQ-046 IF only: if_req=1, if_addr=0x010, mem_do=0xA5A5_0001 -> gnt_if in cycles 1-2, mem_a=0x010, if_ack in cycle 3, if_rdata=0xA5A5_0001.
REQ-047 DM store: dm_rw=1, dm_size=2'b00, dm_addr=0x044, dm_wdata=0x0000_00EE -> mem_rw=1, mem_e=1, mem_di=0xEE in cycles 1-2, dm_ack in cycle 3, dm_rdata unchanged.
REQ-048 Continuous tie, both reqs held and each re-requested after ack -> grant order DM, DM, IF, DM, DM, IF.
REQ-049 With STARVE_MAX=0 -> IF wins every tie and starve_cnt stays 0.
REQ-050 Reset asserted mid-ACC of a DM store -> mem_e=0 the same cycle, no dm_ack; after release, a pending if_req is granted first when dm_req is low.
REQ-051 if_addr and dm_wdata changed during ACC -> mem_a/mem_di keep the latched values until RESP.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between an instruction-fetch (IF) and a data-memory (DM) requester
// Ports:
//   clk, reset                  clock and asynchronous active-high reset
//   if_req/if_addr              fetch request and byte address
//   if_rdata/if_ack             registered fetch word and one-cycle completion pulse
//   dm_req/dm_rw/dm_size/dm_se  data request, store flag, size and load sign-extend
//   dm_addr/dm_wdata            data byte address and store data
//   dm_rdata/dm_ack             registered load data and one-cycle completion pulse
//   mem_a/mem_di/mem_size/mem_rw/mem_e/mem_se/mem_do  shared RAM port
//   gnt_if/gnt_dm               current RAM owner, high only while accessing
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 0,
    parameter int STARVE_MAX  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [8:0]  if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_rw,
    input  logic [1:0]  dm_size,
    input  logic        dm_se,
    input  logic [8:0]  dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic [8:0]  mem_a,
    output logic [31:0] mem_di,
    output logic [1:0]  mem_size,
    output logic        mem_rw,
    output logic        mem_e,
    output logic        mem_se,
    input  logic [31:0] mem_do,
    output logic        gnt_if,
    output logic        gnt_dm
);
    localparam int WW = $clog2(WAIT_CYCLES + 2);
    localparam int SW = $clog2(STARVE_MAX + 2);
    localparam logic [WW-1:0] WMAX = WW'(WAIT_CYCLES);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
    state_t        state_q, state_d;
    logic          dm_own_q, dm_own_d;
    logic [8:0]    a_q, a_d;
    logic [31:0]   di_q, di_d;
    logic [1:0]    size_q, size_d;
    logic          rw_q, rw_d;
    logic          se_q, se_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          if_win, acc;
    // IF wins when alone, or on a tie once it has lost STARVE_MAX ties in a row
    assign if_win = if_req && (!dm_req || starve_q >= SMAX);
    always_comb begin
        state_d    = state_q;
        dm_own_d   = dm_own_q;
        a_d        = a_q;
        di_d       = di_q;
        size_d     = size_q;
        rw_d       = rw_q;
        se_d       = se_q;
        wcnt_d     = wcnt_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            IDLE: if (if_req || dm_req) begin
                state_d  = ACC;
                dm_own_d = !if_win;
                wcnt_d   = WMAX;
                a_d      = if_win ? if_addr : dm_addr;
                di_d     = if_win ? '0 : dm_wdata;
                size_d   = if_win ? 2'b10 : dm_size;
                rw_d     = if_win ? 1'b0 : dm_rw;
                se_d     = if_win ? 1'b0 : dm_se;
                starve_d = if_win ? '0 : (if_req && starve_q < SMAX) ? starve_q + 1'b1 : starve_q;
            end
            ACC: if (wcnt_q != '0) begin
                wcnt_d = wcnt_q - 1'b1;
            end else begin
                state_d    = RESP;
                if_rdata_d = (!rw_q && !dm_own_q) ? mem_do : if_rdata_q;
                dm_rdata_d = (!rw_q && dm_own_q) ? mem_do : dm_rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dm_own_q   <= 1'b0;
            a_q        <= '0;
            di_q       <= '0;
            size_q     <= '0;
            rw_q       <= 1'b0;
            se_q       <= 1'b0;
            wcnt_q     <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            dm_own_q   <= dm_own_d;
            a_q        <= a_d;
            di_q       <= di_d;
            size_q     <= size_d;
            rw_q       <= rw_d;
            se_q       <= se_d;
            wcnt_q     <= wcnt_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end
    // RAM port is driven only from latched fields, and only while accessing
    assign acc      = state_q == ACC;
    assign mem_e    = acc;
    assign mem_a    = acc ? a_q : '0;
    assign mem_di   = acc ? di_q : '0;
    assign mem_size = acc ? size_q : '0;
    assign mem_rw   = acc && rw_q;
    assign mem_se   = acc && se_q;
    assign gnt_if   = acc && !dm_own_q;
    assign gnt_dm   = acc && dm_own_q;
    assign if_ack   = state_q == RESP && !dm_own_q;
    assign dm_ack   = state_q == RESP && dm_own_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (WAIT_CYCLES=1; STARVE_MAX=2 and 0)
module tb_mem_port_arbiter;
    logic clk, reset, if_req, dm_req, dm_rw, dm_se;
    logic [8:0] if_addr, dm_addr;
    logic [1:0] dm_size;
    logic [31:0] dm_wdata, mem_do;
    logic [31:0] if_rdata, dm_rdata, mem_di;
    logic if_ack, dm_ack, mem_rw, mem_e, mem_se, gnt_if, gnt_dm;
    logic [8:0] mem_a;
    logic [1:0] mem_size;
    logic [31:0] if_rdata_1, dm_rdata_1, mem_di_1;
    logic if_ack_1, dm_ack_1, mem_rw_1, mem_e_1, mem_se_1, gnt_if_1, gnt_dm_1;
    logic [8:0] mem_a_1;
    logic [1:0] mem_size_1;
    typedef struct {bit is_dm; logic [31:0] rd; int cyc;} exp_t;
    exp_t q0[$];
    bit q1[$];
    int n_chk = 0, n_fail = 0, cyc = 0, c0;
    bit chk1 = 0;
    mem_port_arbiter #(.WAIT_CYCLES(1), .STARVE_MAX(2)) dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_rw(dm_rw), .dm_size(dm_size), .dm_se(dm_se), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .mem_a(mem_a), .mem_di(mem_di),
        .mem_size(mem_size), .mem_rw(mem_rw), .mem_e(mem_e), .mem_se(mem_se), .mem_do(mem_do),
        .gnt_if(gnt_if), .gnt_dm(gnt_dm));
    mem_port_arbiter #(.WAIT_CYCLES(1), .STARVE_MAX(0)) dut0 (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_1), .if_ack(if_ack_1),
        .dm_req(dm_req), .dm_rw(dm_rw), .dm_size(dm_size), .dm_se(dm_se), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata_1), .dm_ack(dm_ack_1), .mem_a(mem_a_1), .mem_di(mem_di_1),
        .mem_size(mem_size_1), .mem_rw(mem_rw_1), .mem_e(mem_e_1), .mem_se(mem_se_1), .mem_do(mem_do),
        .gnt_if(gnt_if_1), .gnt_dm(gnt_dm_1));
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask
    task automatic push0(input bit d, input logic [31:0] rd, input int c);
        exp_t e;
        e.is_dm = d;
        e.rd = rd;
        e.cyc = c;
        q0.push_back(e);
    endtask
    task automatic start();
        @(posedge clk);
        #1;
        c0 = cyc;
    endtask
    // monitor: every ack pops the next expected completion
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_ack || dm_ack) begin
                if (q0.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ack: if_ack=%0b dm_ack=%0b, want no ack", if_ack, dm_ack);
                end else begin
                    e = q0.pop_front();
                    chk("ack_who", {30'd0, if_ack, dm_ack}, e.is_dm ? 32'd1 : 32'd2);
                    chk("ack_cycle", cyc, e.cyc);
                    chk("ack_rdata", e.is_dm ? dm_rdata : if_rdata, e.rd);
                end
            end
            if (chk1 && (if_ack_1 || dm_ack_1)) begin
                if (q1.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ack_s0: if_ack=%0b dm_ack=%0b, want no ack", if_ack_1, dm_ack_1);
                end else chk("s0_ack_who", {30'd0, if_ack_1, dm_ack_1}, q1.pop_front() ? 32'd1 : 32'd2);
            end
        end
    end
    initial begin
        reset = 1; if_req = 0; dm_req = 0; dm_rw = 0; dm_se = 0; dm_size = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_do = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_e", mem_e, 0);
        chk("rst_gnt", {gnt_if, gnt_dm}, 0);
        chk("rst_ack", {if_ack, dm_ack}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_mem_a", mem_a, 0);
        reset = 0;
        // fetch only
        start();
        if_req = 1; if_addr = 9'h010; mem_do = 32'hA5A5_0001;
        push0(0, 32'hA5A5_0001, c0 + 3);
        @(negedge clk);
        chk("if_gnt_c0", gnt_if, 0);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            chk("if_gnt", gnt_if, 1);
            chk("if_mem_e", mem_e, 1);
            chk("if_mem_a", mem_a, 9'h010);
            chk("if_mem_size", mem_size, 2'b10);
        end
        @(negedge clk);
        chk("resp_mem_e", mem_e, 0);
        chk("resp_gnt", {gnt_if, gnt_dm}, 0);
        if_req = 0;
        // data store
        start();
        dm_req = 1; dm_rw = 1; dm_size = 2'b00; dm_addr = 9'h044; dm_wdata = 32'h0000_00EE; mem_do = 32'hDEAD_BEEF;
        push0(1, 32'h0, c0 + 3);
        @(negedge clk);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            chk("st_gnt_dm", gnt_dm, 1);
            chk("st_mem_rw", mem_rw, 1);
            chk("st_mem_di", mem_di, 32'hEE);
            chk("st_mem_a", mem_a, 9'h044);
            chk("st_mem_size", mem_size, 0);
        end
        @(negedge clk);
        chk("st_resp_mem_di", mem_di, 0);
        chk("st_resp_mem_rw", mem_rw, 0);
        dm_req = 0;
        // data load, sign-extend, half size
        start();
        dm_req = 1; dm_rw = 0; dm_size = 2'b01; dm_se = 1; dm_addr = 9'h008; mem_do = 32'h1234_5678;
        push0(1, 32'h1234_5678, c0 + 3);
        repeat (2) @(negedge clk);
        chk("ld_mem_se", mem_se, 1);
        chk("ld_mem_size", mem_size, 2'b01);
        chk("ld_mem_rw", mem_rw, 0);
        repeat (2) @(negedge clk);
        chk("ld_if_rdata_hold", if_rdata, 32'hA5A5_0001);
        dm_req = 0; dm_se = 0;
        // fetch: address changed and request dropped during the access
        start();
        if_req = 1; if_addr = 9'h020; mem_do = 32'h0F0F_0F0F;
        push0(0, 32'h0F0F_0F0F, c0 + 3);
        repeat (2) @(negedge clk);
        chk("chg_mem_a1", mem_a, 9'h020);
        if_addr = 9'h1FF; if_req = 0;
        @(negedge clk);
        chk("chg_mem_a2", mem_a, 9'h020);
        @(negedge clk);
        // store: write data changed during the access
        start();
        dm_req = 1; dm_rw = 1; dm_size = 2'b10; dm_addr = 9'h060; dm_wdata = 32'h11;
        push0(1, 32'h1234_5678, c0 + 3);
        repeat (2) @(negedge clk);
        chk("chg_mem_di1", mem_di, 32'h11);
        dm_wdata = 32'h22;
        @(negedge clk);
        chk("chg_mem_di2", mem_di, 32'h11);
        @(negedge clk);
        dm_req = 0;
        // continuous tie, re-requests after each ack
        start();
        chk1 = 1;
        if_req = 1; if_addr = 9'h040; dm_req = 1; dm_rw = 0; dm_addr = 9'h030; mem_do = 32'h0000_0C0C;
        for (int k = 0; k < 6; k++) begin
            push0(k % 3 != 2, 32'h0000_0C0C, c0 + 3 + 4 * k);
            q1.push_back(0);
        end
        repeat (24) @(negedge clk);
        if_req = 0; dm_req = 0;
        @(negedge clk);
        chk1 = 0;
        chk("s0_queue_empty", q1.size(), 0);
        // reset in the middle of a store access
        start();
        dm_req = 1; dm_rw = 1; dm_addr = 9'h050; dm_wdata = 32'h77;
        repeat (2) @(negedge clk);
        chk("abort_mem_e_pre", mem_e, 1);
        reset = 1;
        #1;
        chk("abort_mem_e", mem_e, 0);
        chk("abort_mem_rw", mem_rw, 0);
        chk("abort_gnt", {gnt_if, gnt_dm}, 0);
        dm_req = 0; dm_rw = 0; if_req = 1; if_addr = 9'h0AA; mem_do = 32'hCAFE_0001;
        @(posedge clk);
        @(negedge clk);
        chk("abort_if_rdata", if_rdata, 0);
        chk("abort_dm_ack", dm_ack, 0);
        chk("abort_gnt_hold", {gnt_if, gnt_dm}, 0);
        reset = 0;
        c0 = cyc;
        push0(0, 32'hCAFE_0001, c0 + 3);
        @(negedge clk);
        chk("post_rst_gnt_if", gnt_if, 1);
        chk("post_rst_mem_a", mem_a, 9'h0AA);
        repeat (2) @(negedge clk);
        if_req = 0;
        repeat (3) @(negedge clk);
        chk("queue_empty", q0.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
